// File: rtl/debounce_defs.sv
// Shared encodings for the debounce/synchronizer block.
package debounce_defs;

  // Two-state qualification FSM encoding.
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_e;

  // True when a candidate level has held for the full qualification window.
  function automatic logic qual_done(input logic [31:0] cnt, input logic [31:0] last);
    return cnt == last;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for one asynchronous input; reusable for any raw pin.
module sync_ff_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  // Shift the raw input through STAGES flops; bit 0 is the first sampler.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_q <= {STAGES{RST_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronize a raw input, then accept a new level only after it holds for
// STABLE_CYCLES enabled ticks. Emits the accepted level and rise/fall pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_STABLE | synchronized input matches dout; waiting for a change
// ST_CHECK  | synchronized input differs from dout; counting ticks
module debounce_sync
  import debounce_defs::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   CNT_W         = 16,
  parameter int   STABLE_CYCLES = 50000,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din_raw,
  input  logic tick,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Last count value of the window; the equality compare stops counting here,
  // so the counter can never wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(RESET_LEVEL)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (din_raw),
    .q    (sync_s)
  );

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      dout_q  <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Qualification: a bounce back aborts regardless of tick; pulses only on accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync_s != dout_q) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end
      end
      ST_CHECK: begin
        if (sync_s == dout_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (qual_done(32'(cnt_q), 32'(CNT_LAST))) begin
            dout_d  = sync_s;
            rise_d  = sync_s;
            fall_d  = ~sync_s;
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == ST_CHECK);

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a delay-line/tick-count model.
module tb_debounce_sync;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam bit RST_LVL = 1'b0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic din_raw = 1'b1;
  logic tick = 1'b1;
  logic dout, rise, fall, busy;

  int checks = 0;
  int failures = 0;

  debounce_sync #(
    .SYNC_STAGES  (SYNC),
    .CNT_W        (16),
    .STABLE_CYCLES(STABLE),
    .RESET_LEVEL  (RST_LVL)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .din_raw(din_raw),
    .tick   (tick),
    .dout   (dout),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the synchronizer is a queue of past samples (oldest = what the
  // qualifier sees); a change is accepted once STABLE ticks elapse while the
  // delayed input keeps disagreeing with the output level.
  bit sq[$];
  bit s_pre;
  bit m_dout = RST_LVL;
  bit m_rise = 1'b0;
  bit m_fall = 1'b0;
  bit m_busy = 1'b0;
  int m_ticks = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq.delete();
      repeat (SYNC) sq.push_back(RST_LVL);
      m_dout = RST_LVL; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0; m_ticks = 0;
    end else begin
      s_pre = sq.pop_front();
      sq.push_back(din_raw);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (!m_busy) begin
        if (s_pre != m_dout) begin m_busy = 1'b1; m_ticks = 0; end
      end else if (s_pre == m_dout) begin
        m_busy = 1'b0;
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == STABLE) begin
          m_dout = s_pre; m_rise = s_pre; m_fall = !s_pre; m_busy = 1'b0;
        end
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    chk("model_dout", int'(dout), int'(m_dout));
    chk("model_rise", int'(rise), int'(m_rise));
    chk("model_fall", int'(fall), int'(m_fall));
    chk("model_busy", int'(busy), int'(m_busy));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle(input logic lvl);
    tick = 1'b1;
    din_raw = lvl;
    step(12);
  endtask

  int qt, qt_at_fall, nf, gap, run;
  bit seen_busy, seen_pulse, bprev, got;

  initial begin
    // 1: reset held with din_raw=1, then release; first edge after release is edge 0.
    step(3);
    chk("rst_dout", int'(dout), 0);
    chk("rst_rise", int'(rise), 0);
    chk("rst_fall", int'(fall), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b1;
    step(6);
    chk("rel_dout_e5", int'(dout), 0);
    step(1);
    chk("rel_dout_e6", int'(dout), 1);
    chk("rel_rise_e6", int'(rise), 1);

    // 2: clean 0->1 edge.
    settle(1'b0);
    din_raw = 1'b1;
    step(2);
    chk("clean_busy_e1", int'(busy), 0);
    step(1);
    chk("clean_busy_e2", int'(busy), 1);
    step(3);
    chk("clean_dout_e5", int'(dout), 0);
    step(1);
    chk("clean_dout_e6", int'(dout), 1);
    chk("clean_rise_e6", int'(rise), 1);
    step(1);
    chk("clean_rise_e7", int'(rise), 0);
    chk("clean_fall_e7", int'(fall), 0);

    // 3: short bounce.
    settle(1'b0);
    din_raw = 1'b1;
    step(2);
    din_raw = 1'b0;
    seen_busy = 1'b0; seen_pulse = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (busy) seen_busy = 1'b1;
      if (rise || fall || dout) seen_pulse = 1'b1;
    end
    chk("bounce_busy_seen", int'(seen_busy), 1);
    chk("bounce_no_change", int'(seen_pulse), 0);
    chk("bounce_busy_end", int'(busy), 0);

    // 4: tick every 3rd clock, 1->0.
    settle(1'b1);
    din_raw = 1'b0;
    qt = 0; nf = 0; qt_at_fall = -1;
    for (int i = 0; i < 60; i++) begin
      tick = (i % 3 == 0);
      bprev = busy;
      step(1);
      if (bprev && tick) qt++;
      if (fall) begin
        nf++;
        if (qt_at_fall < 0) qt_at_fall = qt;
      end
    end
    tick = 1'b1;
    chk("tick_fall_count", nf, 1);
    chk("tick_qual_ticks", qt_at_fall, 4);
    chk("tick_dout", int'(dout), 0);

    // 5: async reset with cnt=2 (entry at edge 2, cnt 1 at edge 3, 2 at edge 4).
    settle(1'b0);
    din_raw = 1'b1;
    step(5);
    chk("mid_busy_pre", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_busy_rst", int'(busy), 0);
    chk("mid_dout_rst", int'(dout), 0);
    chk("mid_rise_rst", int'(rise), 0);
    @(negedge clk);
    reset = 1'b1;
    step(6);
    chk("mid_requal_e5", int'(dout), 0);
    step(1);
    chk("mid_requal_e6", int'(rise), 1);

    // 6: back-to-back; the 1->0 change is first sampled one edge after the rise.
    settle(1'b0);
    din_raw = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1);
      if (rise) got = 1'b1;
    end
    chk("b2b_rise_seen", int'(got), 1);
    din_raw = 1'b0;
    gap = -1;
    for (int i = 1; i <= 20 && gap < 0; i++) begin
      step(1);
      if (fall) gap = i;
    end
    chk("b2b_gap", gap, 7);
    chk("b2b_dout", int'(dout), 0);

    // Randomized: runs of varying length, random tick, occasional async reset.
    for (int r = 0; r < 400; r++) begin
      run = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(3, 14);
      din_raw = ~din_raw;
      for (int c = 0; c < run; c++) begin
        tick = ($urandom_range(0, 3) != 0) || (r % 5 == 0);
        step(1);
        if ($urandom_range(0, 199) == 0) begin
          #3 reset = 1'b0;
          @(negedge clk);
          reset = 1'b1;
        end
      end
    end

    tick = 1'b1;
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
